cpu_executor: RTL
=================

Name: cpu_executor

Overview:
- Execute stage directly downstream of the combinational instruction decoder.
- Consumes decoded opcode/regop1/regop2/immop1 for the instruction at the current bit-addressed pc, and owns the pc, register file, zero flag and I/O handshakes.
- Single-cycle ops retire in one clock. mul/div are iterative multi-cycle; out/imp stall on valid/ready handshakes.
- Drives pc back to the decoder, closing the fetch/decode/execute loop.

Parameters:
- OPSZ, cpu_inst_opcode_sz, opcode width.
- RGSZ, cpu_inst_regop_sz, register index width; register count NREGS = 2**RGSZ.
- IMSZ, cpu_inst_immop_sz, immediate width.
- PCSZ, cpu_pc_sz, pc width (bit address into code).
- WORD_SZ, 8, register/data width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  OPSZ  decoded opcode (cpu_inst_opcode_* encodings)
- regop1  in  RGSZ  first register index
- regop2  in  RGSZ  second register index
- immop1  in  IMSZ  immediate / jump target
- pc  out  PCSZ  current instruction bit address, to decoder
- out_data  out  WORD_SZ  output port data
- out_valid  out  1  output data valid
- out_ready  in  1  sink accepts out_data
- in_data  in  WORD_SZ  input port data
- in_valid  in  1  source offers in_data
- in_ready  out  1  executor accepts in_data
- busy  out  1  high while not in EXEC state
- fault  out  1  sticky: divide-by-zero or illegal opcode

Behaviour:
- Reset (async, rst_n low): pc=0, all regs=0, zflag=0, out_valid=0, out_data=0, in_ready=0, busy=0, fault=0, state=EXEC. Reset mid-mul/div/handshake aborts the operation with no register write.
- States: EXEC, MUL, DIV, OUT_WAIT, IN_WAIT, HALT. busy = (state != EXEC).
- Issue: in EXEC, on each clock edge, latch opcode, indices, immop1 and operand values A=regs[regop1], B=regs[regop2]. Latching values makes r1==r2 well defined.
- Instruction lengths L: imm = OPSZ+RGSZ+IMSZ; out/imp/iz/inc/dec = OPSZ+RGSZ; add/sub/mul/div/and/or/xor = OPSZ+2*RGSZ; jmp/jz = OPSZ+IMSZ.
- Retire: pc <= pc+L, modulo 2**PCSZ (wraps silently).
- Single-cycle in EXEC, retiring on the same edge:
  - imm: r1 <= immop1 zero-extended or truncated to WORD_SZ.
  - inc/dec: r1 <= r1 ± 1, wrapping.
  - add/sub/and/or/xor: r1 <= A op B, low WORD_SZ bits, wrapping.
  - iz: zflag <= (A==0); registers unchanged.
  - jmp: pc <= immop1 zero-extended to PCSZ.
  - jz: if zflag, pc <= immop1; else pc <= pc+L. zflag is not cleared.
- mul: EXEC -> MUL for exactly WORD_SZ cycles of shift-add. Writes r1 <= low WORD_SZ bits of A*B, retires and returns to EXEC. Issue-to-retire = WORD_SZ+1 edges.
- div: if B==0, fault<=1 and state -> HALT; no write, pc unchanged. Otherwise EXEC -> DIV for WORD_SZ cycles of restoring division, then r1 <= A/B (unsigned quotient), retire.
- out: EXEC -> OUT_WAIT with out_valid<=1, out_data<=A. Each cycle with out_valid && out_ready: out_valid<=0, retire, -> EXEC. out_data holds stable while out_valid is high. out_ready high at issue still costs one OUT_WAIT cycle.
- imp: EXEC -> IN_WAIT with in_ready<=1. On in_valid && in_ready: r1 <= in_data, in_ready<=0, retire, -> EXEC. in_valid is ignored outside IN_WAIT.
- Illegal opcode (any encoding not listed): fault<=1, -> HALT.
- HALT: absorbing until reset. pc frozen, no writes, out_valid=0, in_ready=0.
- Decoder is combinational from pc, so inputs are only sampled in EXEC.

Optional Feature:
- Macro: CPU_EXEC_FAST_MUL_EN.
- Defined: mul completes in EXEC as single-cycle (combinational multiplier), retiring one edge after issue; MUL state is unused.
- Undefined: iterative WORD_SZ-cycle multiply as above. Results are identical either way.

Test Plan:
- imm r1,5; imm r2,3; add r1,r2 -> r1=8; pc advances by 15,15,10 (OPSZ=4, RGSZ=3, IMSZ=8).
- imm r0,0xFF; inc r0; iz r0; jz 0x40 -> r0=0x00, zflag=1, pc=0x40.
- imm r3,13; imm r4,4; mul r3,r4; div r3,r4 -> after mul r3=0x34 (busy high 8 cycles without macro, 0 with); after div r3=13.
- imm r5,7; div r5,r6 with r6=0 -> fault=1, pc stays at the div address, r5=7, no further writes.
- out r1 (r1=8), out_ready low 3 cycles then high -> out_valid high 4 cycles, out_data=8 throughout, pc advances once.
- imp r2 with in_valid at cycle 2 carrying 0xA5; assert rst_n low during a mul -> r2=0xA5 and in_ready drops after the transfer; reset returns pc=0, all regs=0, busy=0 asynchronously.

Source files
------------

// File: rtl/cpu_executor.sv
// -----------------------------------------------------------------------------
// cpu_executor_pkg / cpu_executor
//
// Execute stage that sits directly after the combinational instruction decoder.
// It owns the program counter, the register file, the zero flag and the I/O
// handshakes. The current pc goes back to the decoder, which returns the
// decoded fields for the instruction at that bit address.
//
// Optional feature (compile-time macro CPU_EXEC_FAST_MUL_EN):
//   defined   - mul uses a combinational multiplier and retires in EXEC in one
//               clock, like the other single-cycle ops (MUL state unused).
//   undefined - mul is an iterative shift-add taking WORD_SZ cycles in MUL.
//   The result is the same in both builds.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   opcode            decoded opcode (cpu_inst_opcode_* encodings)
//   regop1, regop2    register indices
//   immop1            immediate / jump target
//   pc                current instruction bit address (to decoder)
//   out_data/valid    output port, held stable until out_ready
//   out_ready         sink accepts out_data
//   in_data/valid     input port offered by source
//   in_ready          executor accepts in_data (only while waiting on imp)
//   busy              high whenever the state is not EXEC
//   fault             sticky divide-by-zero / illegal-opcode flag
// -----------------------------------------------------------------------------
package cpu_executor_pkg;

  localparam int cpu_inst_opcode_sz = 4;
  localparam int cpu_inst_regop_sz  = 3;
  localparam int cpu_inst_immop_sz  = 8;
  localparam int cpu_pc_sz          = 8;

  localparam logic [3:0] cpu_inst_opcode_imm = 4'h0;
  localparam logic [3:0] cpu_inst_opcode_add = 4'h1;
  localparam logic [3:0] cpu_inst_opcode_sub = 4'h2;
  localparam logic [3:0] cpu_inst_opcode_mul = 4'h3;
  localparam logic [3:0] cpu_inst_opcode_div = 4'h4;
  localparam logic [3:0] cpu_inst_opcode_and = 4'h5;
  localparam logic [3:0] cpu_inst_opcode_or  = 4'h6;
  localparam logic [3:0] cpu_inst_opcode_xor = 4'h7;
  localparam logic [3:0] cpu_inst_opcode_inc = 4'h8;
  localparam logic [3:0] cpu_inst_opcode_dec = 4'h9;
  localparam logic [3:0] cpu_inst_opcode_iz  = 4'hA;
  localparam logic [3:0] cpu_inst_opcode_jmp = 4'hB;
  localparam logic [3:0] cpu_inst_opcode_jz  = 4'hC;
  localparam logic [3:0] cpu_inst_opcode_out = 4'hD;
  localparam logic [3:0] cpu_inst_opcode_imp = 4'hE;
  // 4'hF is not an instruction and raises fault.

endpackage

module cpu_executor
  import cpu_executor_pkg::*;
#(
  parameter int OPSZ    = cpu_inst_opcode_sz,
  parameter int RGSZ    = cpu_inst_regop_sz,
  parameter int IMSZ    = cpu_inst_immop_sz,
  parameter int PCSZ    = cpu_pc_sz,
  parameter int WORD_SZ = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OPSZ-1:0]    opcode,
  input  logic [RGSZ-1:0]    regop1,
  input  logic [RGSZ-1:0]    regop2,
  input  logic [IMSZ-1:0]    immop1,
  output logic [PCSZ-1:0]    pc,
  output logic [WORD_SZ-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic [WORD_SZ-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               busy,
  output logic               fault
);

  localparam int NREGS = 2 ** RGSZ;
  localparam int CNTW  = (WORD_SZ > 1) ? $clog2(WORD_SZ) : 1;

  localparam logic [CNTW-1:0]    CNT_LAST = CNTW'(WORD_SZ - 1);
  localparam logic [CNTW-1:0]    CNT_ONE  = CNTW'(1);
  localparam logic [WORD_SZ-1:0] ONE      = WORD_SZ'(1);

  // Instruction lengths in bits, by operand format.
  localparam logic [PCSZ-1:0] LEN_IMM = PCSZ'(OPSZ + RGSZ + IMSZ);
  localparam logic [PCSZ-1:0] LEN_R1  = PCSZ'(OPSZ + RGSZ);
  localparam logic [PCSZ-1:0] LEN_R2  = PCSZ'(OPSZ + 2 * RGSZ);
  localparam logic [PCSZ-1:0] LEN_J   = PCSZ'(OPSZ + IMSZ);

  localparam logic [OPSZ-1:0] OP_IMM = OPSZ'(cpu_inst_opcode_imm);
  localparam logic [OPSZ-1:0] OP_ADD = OPSZ'(cpu_inst_opcode_add);
  localparam logic [OPSZ-1:0] OP_SUB = OPSZ'(cpu_inst_opcode_sub);
  localparam logic [OPSZ-1:0] OP_MUL = OPSZ'(cpu_inst_opcode_mul);
  localparam logic [OPSZ-1:0] OP_DIV = OPSZ'(cpu_inst_opcode_div);
  localparam logic [OPSZ-1:0] OP_AND = OPSZ'(cpu_inst_opcode_and);
  localparam logic [OPSZ-1:0] OP_OR  = OPSZ'(cpu_inst_opcode_or);
  localparam logic [OPSZ-1:0] OP_XOR = OPSZ'(cpu_inst_opcode_xor);
  localparam logic [OPSZ-1:0] OP_INC = OPSZ'(cpu_inst_opcode_inc);
  localparam logic [OPSZ-1:0] OP_DEC = OPSZ'(cpu_inst_opcode_dec);
  localparam logic [OPSZ-1:0] OP_IZ  = OPSZ'(cpu_inst_opcode_iz);
  localparam logic [OPSZ-1:0] OP_JMP = OPSZ'(cpu_inst_opcode_jmp);
  localparam logic [OPSZ-1:0] OP_JZ  = OPSZ'(cpu_inst_opcode_jz);
  localparam logic [OPSZ-1:0] OP_OUT = OPSZ'(cpu_inst_opcode_out);
  localparam logic [OPSZ-1:0] OP_IMP = OPSZ'(cpu_inst_opcode_imp);

  typedef enum logic [2:0] {
    ST_EXEC,
    ST_MUL,
    ST_DIV,
    ST_OUT_WAIT,
    ST_IN_WAIT,
    ST_HALT
  } state_e;

  function automatic logic [PCSZ-1:0] inst_len(input logic [OPSZ-1:0] op);
    case (op)
      OP_IMM:                               inst_len = LEN_IMM;
      OP_OUT, OP_IMP, OP_IZ, OP_INC, OP_DEC: inst_len = LEN_R1;
      OP_JMP, OP_JZ:                        inst_len = LEN_J;
      default:                              inst_len = LEN_R2;
    endcase
  endfunction

  // Architectural state
  state_e             state_q, state_d;
  logic [PCSZ-1:0]    pc_q, pc_d;
  logic [WORD_SZ-1:0] regs_q [NREGS];
  logic [WORD_SZ-1:0] regs_d [NREGS];
  logic               zflag_q, zflag_d;
  logic               fault_q, fault_d;
  logic               out_valid_q, out_valid_d;
  logic [WORD_SZ-1:0] out_data_q, out_data_d;
  logic               in_ready_q, in_ready_d;

  // Issue latches and the shared mul/div iteration datapath.
  //   mul: acc = partial product, mcand = shifted A, wrk = B shifting right
  //   div: acc = remainder,       mcand = divisor B,  wrk = A -> quotient
  logic [OPSZ-1:0]    op_q, op_d;
  logic [RGSZ-1:0]    r1_q, r1_d;
  logic [WORD_SZ-1:0] acc_q, acc_d;
  logic [WORD_SZ-1:0] mcand_q, mcand_d;
  logic [WORD_SZ-1:0] wrk_q, wrk_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;

  logic [WORD_SZ-1:0] opa, opb;
  logic [PCSZ-1:0]    issue_pc_nxt, retire_pc_nxt;

  assign opa           = regs_q[regop1];
  assign opb           = regs_q[regop2];
  assign issue_pc_nxt  = pc_q + inst_len(opcode);
  assign retire_pc_nxt = pc_q + inst_len(op_q);

  // One shift-add step; only the low WORD_SZ product bits are ever kept.
  logic [WORD_SZ-1:0] mul_acc_nxt;
  assign mul_acc_nxt = acc_q + (wrk_q[0] ? mcand_q : '0);

  // One restoring-division step. The remainder is always below the divisor,
  // so the borrow out of the WORD_SZ+1-bit subtraction decides the quotient bit.
  logic [WORD_SZ:0]   div_sh, div_sub;
  logic               div_ge;
  logic [WORD_SZ-1:0] div_rem_nxt, div_quo_nxt;
  assign div_sh      = {acc_q, wrk_q[WORD_SZ-1]};
  assign div_sub     = div_sh - {1'b0, mcand_q};
  assign div_ge      = ~div_sub[WORD_SZ];
  assign div_rem_nxt = div_ge ? div_sub[WORD_SZ-1:0] : div_sh[WORD_SZ-1:0];
  assign div_quo_nxt = {wrk_q[WORD_SZ-2:0], div_ge};

  always_comb begin
    // NOTE: every signal gets a default before the case tree, so a path that
    // forgets to assign one holds its flop instead of inferring a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    regs_d      = regs_q;
    zflag_d     = zflag_q;
    fault_d     = fault_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    in_ready_d  = in_ready_q;
    op_d        = op_q;
    r1_d        = r1_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    wrk_d       = wrk_q;
    cnt_d       = cnt_q;

    case (state_q)
      ST_EXEC: begin
        op_d = opcode;
        r1_d = regop1;
        case (opcode)
          OP_IMM: begin
            regs_d[regop1] = WORD_SZ'(immop1);
            pc_d           = issue_pc_nxt;
          end
          OP_INC: begin
            regs_d[regop1] = opa + ONE;
            pc_d           = issue_pc_nxt;
          end
          OP_DEC: begin
            regs_d[regop1] = opa - ONE;
            pc_d           = issue_pc_nxt;
          end
          OP_ADD: begin
            regs_d[regop1] = opa + opb;
            pc_d           = issue_pc_nxt;
          end
          OP_SUB: begin
            regs_d[regop1] = opa - opb;
            pc_d           = issue_pc_nxt;
          end
          OP_AND: begin
            regs_d[regop1] = opa & opb;
            pc_d           = issue_pc_nxt;
          end
          OP_OR: begin
            regs_d[regop1] = opa | opb;
            pc_d           = issue_pc_nxt;
          end
          OP_XOR: begin
            regs_d[regop1] = opa ^ opb;
            pc_d           = issue_pc_nxt;
          end
          OP_IZ: begin
            zflag_d = (opa == '0);
            pc_d    = issue_pc_nxt;
          end
          OP_JMP: pc_d = PCSZ'(immop1);
          OP_JZ:  pc_d = zflag_q ? PCSZ'(immop1) : issue_pc_nxt;
          OP_MUL: begin
`ifdef CPU_EXEC_FAST_MUL_EN
            regs_d[regop1] = opa * opb;
            pc_d           = issue_pc_nxt;
`else
            state_d = ST_MUL;
            acc_d   = '0;
            mcand_d = opa;
            wrk_d   = opb;
            cnt_d   = '0;
`endif
          end
          OP_DIV: begin
            if (opb == '0) begin
              fault_d = 1'b1;
              state_d = ST_HALT;
            end else begin
              state_d = ST_DIV;
              acc_d   = '0;
              mcand_d = opb;
              wrk_d   = opa;
              cnt_d   = '0;
            end
          end
          OP_OUT: begin
            state_d     = ST_OUT_WAIT;
            out_valid_d = 1'b1;
            out_data_d  = opa;
          end
          OP_IMP: begin
            state_d    = ST_IN_WAIT;
            in_ready_d = 1'b1;
          end
          default: begin
            fault_d = 1'b1;
            state_d = ST_HALT;
          end
        endcase
      end

      ST_MUL: begin
        acc_d   = mul_acc_nxt;
        mcand_d = mcand_q << 1;
        wrk_d   = wrk_q >> 1;
        cnt_d   = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          regs_d[r1_q] = mul_acc_nxt;
          pc_d         = retire_pc_nxt;
          state_d      = ST_EXEC;
        end
      end

      ST_DIV: begin
        acc_d = div_rem_nxt;
        wrk_d = div_quo_nxt;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          regs_d[r1_q] = div_quo_nxt;
          pc_d         = retire_pc_nxt;
          state_d      = ST_EXEC;
        end
      end

      ST_OUT_WAIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          pc_d        = retire_pc_nxt;
          state_d     = ST_EXEC;
        end
      end

      ST_IN_WAIT: begin
        if (in_valid && in_ready_q) begin
          regs_d[r1_q] = in_data;
          in_ready_d   = 1'b0;
          pc_d         = retire_pc_nxt;
          state_d      = ST_EXEC;
        end
      end

      ST_HALT: ;

      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EXEC;
      pc_q        <= '0;
      // NOTE: the register file is architecturally zero after reset, so it is
      // reset like any other flop rather than mapped to an unreset RAM.
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      zflag_q     <= 1'b0;
      fault_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b0;
      op_q        <= '0;
      r1_q        <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      wrk_q       <= '0;
      cnt_q       <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge values.
      state_q     <= state_d;
      pc_q        <= pc_d;
      regs_q      <= regs_d;
      zflag_q     <= zflag_d;
      fault_q     <= fault_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      op_q        <= op_d;
      r1_q        <= r1_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      wrk_q       <= wrk_d;
      cnt_q       <= cnt_d;
    end
  end

  assign pc        = pc_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign fault     = fault_q;
  assign busy      = (state_q != ST_EXEC);

endmodule
